alu_share_arb: RTL and testbench



---
 rtl/alu_arb_defs.sv | 20 ++
 rtl/alu_exec_unit.sv | 36 +++
 rtl/alu_share_arb.sv | 146 ++++++++++++++
 tb/tb_alu_share_arb.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_defs.sv
// Shared definitions for the shared-ALU arbiter: opcode encodings and
// arbiter FSM state encodings.
package alu_arb_defs;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_unit.sv
// Combinational execute unit: op/a/b -> result, zero flag, reserved-op flag.
// All arithmetic wraps modulo 2^DW; SLT compares as signed values.
module alu_exec_unit
  import alu_arb_defs::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          err
);

  // Opcode decode; the reserved opcode yields zero and flags an error
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one execute unit among NREQ requesters.
// Single op in flight: IDLE (grant) -> EXEC (evaluate) -> RESP (hold result).
// Optional macro ALU_ARB_PERF_EN adds the perf_ops completed-op counter.
module alu_share_arb
  import alu_arb_defs::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [3*NREQ-1:0]  req_op,
  input  logic [DW*NREQ-1:0] req_a,
  input  logic [DW*NREQ-1:0] req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic [DW-1:0]      resp_result,
  output logic               resp_zero,
  output logic               resp_err
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]        perf_ops
`endif
);

  logic [2:0]    op_arr [NREQ];
  logic [DW-1:0] a_arr  [NREQ];
  logic [DW-1:0] b_arr  [NREQ];

  state_t        state_reg, state_next;
  logic [IDW-1:0] last_grant_reg;
  logic [IDW-1:0] grant;
  logic          any_valid;
  logic          accept;

  logic [2:0]    op_reg;
  logic [DW-1:0] a_reg, b_reg;
  logic [IDW-1:0] id_reg;

  logic [DW-1:0] exec_result;
  logic          exec_zero, exec_err;

  // Unpack the flat request buses into per-requester fields
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_arr[gi] = req_op[3*gi +: 3];
    assign a_arr[gi]  = req_a[DW*gi +: DW];
    assign b_arr[gi]  = req_b[DW*gi +: DW];
  end

  assign any_valid = |req_valid;
  assign accept    = (state_reg == S_IDLE) && any_valid && !rst;

  // Round-robin search from last_grant+1 upward; scanning from the far end
  // down lets the nearest valid requester overwrite the others
  always_comb begin
    grant = last_grant_reg;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(last_grant_reg) + k) % NREQ]) begin
        grant = IDW'((int'(last_grant_reg) + k) % NREQ);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; IDLE is always visited between operations
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (any_valid) state_next = S_EXEC;
      S_EXEC:  state_next = S_RESP;
      S_RESP:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: one-hot accept strobe to the round-robin winner in IDLE
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  alu_exec_unit #(.DW(DW)) u_exec (
    .op     (op_reg),
    .a      (a_reg),
    .b      (b_reg),
    .result (exec_result),
    .zero   (exec_zero),
    .err    (exec_err)
  );

  // Operand latch on grant, result capture in EXEC, release on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= IDW'(NREQ - 1);
      op_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      id_reg         <= '0;
      resp_valid     <= 1'b0;
      resp_id        <= '0;
      resp_result    <= '0;
      resp_zero      <= 1'b0;
      resp_err       <= 1'b0;
    end else begin
      if (state_reg == S_IDLE && any_valid) begin
        op_reg         <= op_arr[grant];
        a_reg          <= a_arr[grant];
        b_reg          <= b_arr[grant];
        id_reg         <= grant;
        last_grant_reg <= grant;
      end
      if (state_reg == S_EXEC) begin
        resp_valid  <= 1'b1;
        resp_id     <= id_reg;
        resp_result <= exec_result;
        resp_zero   <= exec_zero;
        resp_err    <= exec_err;
      end
      if (state_reg == S_RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_ops_reg;

  // Completed-op counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst)                           perf_ops_reg <= '0;
    else if (resp_valid && resp_ready) perf_ops_reg <= perf_ops_reg + 32'd1;
  end

  assign perf_ops = perf_ops_reg;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb (NREQ=4) with a behavioural model.
module tb_alu_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [3*NREQ-1:0]  req_op;
  logic [DW*NREQ-1:0] req_a;
  logic [DW*NREQ-1:0] req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [DW-1:0]      resp_result;
  logic               resp_zero;
  logic               resp_err;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]        perf_ops;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ptr      = NREQ - 1;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arb #(.NREQ(NREQ), .IDW(IDW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_err    (resp_err)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_ops    (perf_ops)
`endif
  );

  // Reference ALU computed directly from the opcode table
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a + b;
      3: return a - b;
      4: return a ^ b;
      5: return ~(a | b);
      6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Round-robin reference: first set bit after pointer p, modulo NREQ
  function automatic int rr_pick(input int p, input logic [3:0] m);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int op, input logic [31:0] a, input logic [31:0] b);
    req_op[3*i +: 3] = op[2:0];
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic wait_grant(output int g, output logic [3:0] rdy, output bit to);
    to = 1'b1;
    g = -1;
    rdy = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        rdy = req_ready;
        for (int k = NREQ - 1; k >= 0; k--) if (rdy[k]) g = k;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_resp(output bit to);
    to = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    ptr = NREQ - 1;
  endtask

  // One isolated op from requester i with resp_ready held high
  task automatic run_single(input int i, input int op, input logic [31:0] a, input logic [31:0] b,
                            output bit to, output int g, output logic [31:0] r,
                            output logic z, output logic e, output int id);
    logic [3:0] rdy;
    bit to1, to2;
    set_req(i, op, a, b);
    req_valid = 4'(1 << i);
    resp_ready = 1'b1;
    wait_grant(g, rdy, to1);
    tick;
    req_valid = '0;
    wait_resp(to2);
    r = resp_result;
    z = resp_zero;
    e = resp_err;
    id = int'(resp_id);
    to = to1 | to2;
    tick;
    $display("txn id=%0d op=%0d a=%h b=%h result=%h zero=%b err=%b", id, op, a, b, r, z, e);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    tick;
    tick;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++;
    if ({resp_id, resp_zero, resp_err} !== '0) begin
      n_fail++; $display("FAIL reset_flags: id=%0d zero=%b err=%b want all 0", resp_id, resp_zero, resp_err);
    end
    n_checks++;
    if (resp_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", resp_result); end
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    rst = 1'b0;
    ptr = NREQ - 1;
    tick;
  endtask

  task automatic test_basic;
    int g;
    logic [3:0] rdy;
    bit to;
    set_req(0, 0, 32'hF0F0F0F0, 32'hFF00FF00);
    req_valid = 4'b0001;
    resp_ready = 1'b1;
    wait_grant(g, rdy, to);
    n_checks++;
    if (to || rdy !== 4'b0001) begin n_fail++; $display("FAIL basic_ready: got %b timeout=%0d want 0001", rdy, to); end
    tick;
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL basic_exec_cycle: resp_valid=%b req_ready=%b want 0/0000", resp_valid, req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || resp_result !== 32'hF000F000 || resp_id !== 2'd0 || resp_zero !== 1'b0 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_resp: valid=%b result=%h id=%0d zero=%b err=%b want 1/f000f000/0/0/0",
                         resp_valid, resp_result, resp_id, resp_zero, resp_err);
    end
    $display("txn id=%0d op=0 a=f0f0f0f0 b=ff00ff00 result=%h", resp_id, resp_result);
    tick;
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_release: resp_valid=%b want 0", resp_valid); end
    ptr = 0;
  endtask

  task automatic test_round_robin;
    logic [31:0] ea [NREQ];
    logic [31:0] eb [NREQ];
    int g, exp, last_c;
    logic [3:0] rdy;
    bit to;
    do_reset;
    for (int i = 0; i < NREQ; i++) begin
      ea[i] = $urandom;
      eb[i] = $urandom;
      set_req(i, i, ea[i], eb[i]);
    end
    req_valid = 4'hF;
    resp_ready = 1'b1;
    last_c = -1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g, rdy, to);
      exp = rr_pick(ptr, 4'hF);
      n_checks++;
      if (to || g != exp || rdy !== (4'b0001 << exp)) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b want %b", n, rdy, 4'b0001 << exp);
      end
      if (n > 0) begin
        n_checks++;
        if (cyc - last_c != 3) begin n_fail++; $display("FAIL rr_spacing%0d: got %0d cycles want 3", n, cyc - last_c); end
      end
      last_c = cyc;
      ptr = exp;
      tick;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b1 || int'(resp_id) != exp || resp_result !== ref_alu(exp, ea[exp], eb[exp])) begin
        n_fail++; $display("FAIL rr_resp%0d: valid=%b id=%0d result=%h want 1/%0d/%h",
                           n, resp_valid, resp_id, resp_result, exp, ref_alu(exp, ea[exp], eb[exp]));
      end
      $display("txn id=%0d op=%0d result=%h", resp_id, exp, resp_result);
    end
    req_valid = '0;
    tick;
  endtask

  task automatic test_add_slt;
    bit to;
    int g, id;
    logic [31:0] r;
    logic z, e;
    run_single(2, 2, 32'hFFFFFFFF, 32'd1, to, g, r, z, e, id);
    ptr = 2;
    n_checks++;
    if (to || r !== 32'd0 || z !== 1'b1 || e !== 1'b0 || id != 2) begin
      n_fail++; $display("FAIL add_wrap: result=%h zero=%b err=%b id=%0d want 0/1/0/2", r, z, e, id);
    end
    run_single(1, 6, 32'h80000000, 32'd1, to, g, r, z, e, id);
    ptr = 1;
    n_checks++;
    if (to || r !== 32'd1 || z !== 1'b0 || e !== 1'b0) begin
      n_fail++; $display("FAIL slt_neg: result=%h zero=%b err=%b want 1/0/0", r, z, e);
    end
    run_single(3, 6, 32'd1, 32'h80000000, to, g, r, z, e, id);
    ptr = 3;
    n_checks++;
    if (to || r !== 32'd0 || z !== 1'b1) begin
      n_fail++; $display("FAIL slt_pos: result=%h zero=%b want 0/1", r, z);
    end
    run_single(0, 3, 32'd0, 32'd1, to, g, r, z, e, id);
    ptr = 0;
    n_checks++;
    if (to || r !== 32'hFFFFFFFF || z !== 1'b0) begin
      n_fail++; $display("FAIL sub_wrap: result=%h zero=%b want ffffffff/0", r, z);
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] mask, rdy;
    logic [31:0] oa, ob;
    logic [39:0] snap;
    int exp, other, g;
    bit to;
    mask = 4'b1010;
    exp = rr_pick(ptr, mask);
    other = (exp == 1) ? 3 : 1;
    oa = $urandom;
    ob = $urandom;
    set_req(exp, 7, $urandom, $urandom);
    set_req(other, 2, oa, ob);
    req_valid = mask;
    resp_ready = 1'b0;
    wait_grant(g, rdy, to);
    n_checks++;
    if (to || g != exp) begin n_fail++; $display("FAIL bp_grant: got %0d want %0d", g, exp); end
    ptr = exp;
    tick;
    req_valid = 4'(1 << other);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_exec_ready: got %b want 0000", req_ready); end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || resp_result !== 32'd0 || resp_err !== 1'b1 || resp_zero !== 1'b1 || int'(resp_id) != exp) begin
      n_fail++; $display("FAIL rsv_resp: valid=%b result=%h err=%b zero=%b id=%0d want 1/0/1/1/%0d",
                         resp_valid, resp_result, resp_err, resp_zero, resp_id, exp);
    end
    $display("txn id=%0d op=7 result=%h err=%b", resp_id, resp_result, resp_err);
    snap = {5'b0, resp_valid, resp_id, resp_result};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({5'b0, resp_valid, resp_id, resp_result} !== snap || resp_err !== 1'b1 || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b id=%0d result=%h req_ready=%b", c, resp_valid, resp_id, resp_result, req_ready);
      end
    end
    resp_ready = 1'b1;
    tick;
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: resp_valid=%b want 0", resp_valid); end
    @(negedge clk);
    n_checks++;
    if (req_ready !== (4'b0001 << other)) begin
      n_fail++; $display("FAIL bp_next_grant: got %b want %b", req_ready, 4'b0001 << other);
    end
    ptr = other;
    tick;
    req_valid = '0;
    wait_resp(to);
    n_checks++;
    if (to || resp_result !== (oa + ob) || int'(resp_id) != other) begin
      n_fail++; $display("FAIL bp_second: result=%h id=%0d want %h/%0d", resp_result, resp_id, oa + ob, other);
    end
    $display("txn id=%0d op=2 result=%h", resp_id, resp_result);
    tick;
  endtask

  task automatic test_reset_mid;
    logic [31:0] ea [NREQ];
    logic [31:0] eb [NREQ];
    logic [3:0] rdy;
    int g;
    bit to, seen;
    for (int i = 0; i < NREQ; i++) begin
      ea[i] = $urandom;
      eb[i] = $urandom;
      set_req(i, 4, ea[i], eb[i]);
    end
    req_valid = 4'b0100;
    resp_ready = 1'b1;
    wait_grant(g, rdy, to);
    n_checks++;
    if (to || g != 2) begin n_fail++; $display("FAIL rstmid_grant: got %0d want 2", g); end
    tick;
    rst = 1'b1;
    req_valid = '0;
    tick;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_flush: resp_valid=%b req_ready=%b want 0/0000", resp_valid, req_ready);
    end
    rst = 1'b0;
    ptr = NREQ - 1;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL rstmid_no_resp: got resp_valid=1 want 0"); end
    tick;
    req_valid = 4'hF;
    wait_grant(g, rdy, to);
    n_checks++;
    if (to || g != 0) begin n_fail++; $display("FAIL rstmid_regrant: got %0d want 0", g); end
    ptr = 0;
    tick;
    req_valid = '0;
    wait_resp(to);
    n_checks++;
    if (to || resp_id !== 2'd0 || resp_result !== (ea[0] ^ eb[0])) begin
      n_fail++; $display("FAIL rstmid_resp: id=%0d result=%h want 0/%h", resp_id, resp_result, ea[0] ^ eb[0]);
    end
    $display("txn id=%0d op=4 result=%h", resp_id, resp_result);
    tick;
  endtask

  task automatic test_random;
    int ops [NREQ];
    logic [31:0] as [NREQ];
    logic [31:0] bs [NREQ];
    logic [3:0] mask, rdy;
    logic [31:0] er;
    int exp, g, d;
    bit to;
    for (int n = 0; n < 40; n++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        ops[i] = $urandom_range(0, 7);
        as[i] = $urandom;
        bs[i] = ($urandom_range(0, 7) == 0) ? as[i] : $urandom;
        set_req(i, ops[i], as[i], bs[i]);
      end
      exp = rr_pick(ptr, mask);
      er = ref_alu(ops[exp], as[exp], bs[exp]);
      req_valid = mask;
      resp_ready = 1'b0;
      wait_grant(g, rdy, to);
      n_checks++;
      if (to || g != exp || rdy !== (4'b0001 << exp)) begin
        n_fail++; $display("FAIL rand_grant%0d: got %b want %b (mask %b)", n, rdy, 4'b0001 << exp, mask);
      end
      ptr = exp;
      tick;
      req_valid = '0;
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rand_latency%0d: resp_valid early", n); end
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b1 || int'(resp_id) != exp || resp_result !== er ||
          resp_zero !== (er == 32'd0) || resp_err !== (ops[exp] == 7)) begin
        n_fail++; $display("FAIL rand_resp%0d: valid=%b id=%0d result=%h zero=%b err=%b want 1/%0d/%h/%b/%b",
                           n, resp_valid, resp_id, resp_result, resp_zero, resp_err,
                           exp, er, er == 32'd0, ops[exp] == 7);
      end
      $display("txn id=%0d op=%0d a=%h b=%h result=%h", resp_id, ops[exp], as[exp], bs[exp], resp_result);
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rand_release%0d: resp_valid=%b want 0", n, resp_valid); end
    end
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf;
    bit to;
    int g, id;
    logic [31:0] r;
    logic z, e;
    do_reset;
    n_checks++;
    if (perf_ops !== 32'd0) begin n_fail++; $display("FAIL perf_reset: got %0d want 0", perf_ops); end
    for (int n = 0; n < 10; n++) run_single(n % NREQ, n % 8, $urandom, $urandom, to, g, r, z, e, id);
    n_checks++;
    if (perf_ops !== 32'd10) begin n_fail++; $display("FAIL perf_count: got %0d want 10", perf_ops); end
    force dut.perf_ops_reg = 32'hFFFFFFFE;
    #1;
    release dut.perf_ops_reg;
    run_single(0, 0, $urandom, $urandom, to, g, r, z, e, id);
    n_checks++;
    if (perf_ops !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL perf_max: got %h want ffffffff", perf_ops); end
    run_single(1, 1, $urandom, $urandom, to, g, r, z, e, id);
    n_checks++;
    if (perf_ops !== 32'd0) begin n_fail++; $display("FAIL perf_wrap: got %h want 0", perf_ops); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    test_reset;
    test_basic;
    test_round_robin;
    test_add_slt;
    test_backpressure;
    test_reset_mid;
    test_random;
`ifdef ALU_ARB_PERF_EN
    test_perf;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
